thermocouple_scanner: RTL and testbench
=======================================

Name: thermocouple_scanner

Overview:
Multi-channel successor to the single-channel thermocouple reader. Polls N_CH MAX31855-style thermocouple converters in round-robin order over one shared SPI master. Captures 32-bit frames into per-channel temperature, junction and fault registers. Adds a per-request timeout and per-channel valid flags. Sits between the SPI master and the temperature-monitoring logic.

Parameters:
N_CH, 4, number of thermocouple channels (1..16)
CLK_FREQ, 10, clock cycles per time unit; scales all delays
STARTUP_UNITS, 3, power-up wait before first poll = CLK_FREQ*STARTUP_UNITS cycles
HOLD_UNITS, 1, post-capture hold per channel = CLK_FREQ*HOLD_UNITS cycles
TIMEOUT_CYCLES, 64, max cycles spi_not_busy may stay high after a request
CBITS, 8, counter width; 2^CBITS must exceed every count above

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
spi_not_busy  in  1  SPI master idle flag
spi_rx_data  in  32  last received SPI frame
fault_clr  in  1  clears sticky faults (only used with FAULT_LATCH_EN)
spi_ena  out  1  SPI transfer request
spi_ch_sel  out  clog2(N_CH) (min 1)  chip-select index of the channel being polled
tc_temp_data  out  14*N_CH  packed; channel k at [14k+13:14k]
junction_temp_data  out  12*N_CH  packed
fault_bits  out  4*N_CH  packed; {frame[16], frame[2:0]}
ch_valid  out  N_CH  channel k holds at least one good frame
timeout_err  out  N_CH  last request to channel k timed out
any_fault  out  1  OR of all fault_bits and timeout_err

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n. While rst_n=0, all outputs and internal registers are 0 and state=STARTUP.
- STARTUP: cnt counts from 0 to CLK_FREQ*STARTUP_UNITS. On the cycle after it reaches that value, cnt=0, ch=0, go to REQ.
- REQ:
  - spi_ch_sel=ch.
  - While spi_not_busy=1, spi_ena=1 and cnt increments.
  - When spi_not_busy=0 (transfer started), spi_ena=0, cnt=0, go to WAIT.
  - If cnt reaches TIMEOUT_CYCLES first, then spi_ena=0, timeout_err[ch]=1, ch_valid[ch] keeps its old value, and the FSM goes to HOLD without capturing.
- WAIT: stays while spi_not_busy=0. On the first cycle with spi_not_busy=1 (transfer done), go to CAPTURE.
- CAPTURE (one cycle):
  - Write spi_rx_data[31:18] to tc slot ch, [15:4] to junction slot ch, and {[16],[2:0]} to fault slot ch.
  - Set timeout_err[ch]=0.
  - ch_valid[ch] is set to 1 if frame[16]=0, and cleared to 0 if frame[16]=1.
  - Go to HOLD.
- HOLD: cnt counts to CLK_FREQ*HOLD_UNITS. Then cnt=0, ch = (ch==N_CH-1) ? 0 : ch+1, go to REQ.
- Illegal state encoding: go to REQ with ch=0 on the next cycle.
- Output update rules:
  - Only slot ch is written in CAPTURE; all other slots hold their values.
  - Outputs are registered and update one cycle after the CAPTURE decision.
- any_fault is combinational from the registered outputs.
- An SPI transfer aborted by reset is discarded; the whole sequence restarts from STARTUP.
- N_CH=1: ch stays 0 and spi_ch_sel is a 1-bit constant 0.

Optional Feature:
FAULT_LATCH_EN
- Defined:
  - fault_bits and timeout_err become sticky. CAPTURE ORs new fault bits into the slot, and a good frame does not clear them.
  - fault_clr=1 for one cycle clears every sticky bit on the next edge.
  - If fault_clr=1 coincides with a CAPTURE that sets a fault, the new fault wins and the bit stays 1.
  - ch_valid is unaffected.
- Undefined: fault_clr is ignored and faults reflect the latest frame only.

Test Plan:
- Reset release, N_CH=4, CLK_FREQ=10 -> spi_ena rises exactly 31 cycles after rst_n rises; spi_ch_sel=0.
- Frame 0x1234_5670 on ch0 -> tc slot0=0x048D, junction slot0=0x567, fault slot0=0x0, ch_valid[0]=1. Slots 1-3 remain 0.
- Four consecutive frames -> spi_ch_sel steps 0,1,2,3,0, with each HOLD lasting 11 cycles. Each frame lands only in its own slot.
- Hold spi_not_busy=1 for 70 cycles on ch2 -> timeout_err[2]=1 after 64 cycles and any_fault=1. The scan proceeds to ch3. The next good frame on ch2 clears timeout_err[2].
- Frame with bit16=1, bits[2:0]=3'b101 on ch1 -> fault slot1=4'b1101, ch_valid[1]=0. With FAULT_LATCH_EN, a following good frame keeps 4'b1101 until a fault_clr pulse.
- Drop rst_n mid-WAIT -> all outputs are 0 asynchronously, before the next edge. After release, STARTUP timing repeats as in scenario 1.

Source files
------------

// File: rtl/thermocouple_scanner.sv
// thermocouple_scanner: round-robin poller of N_CH MAX31855-style converters over one shared SPI master.
// Define FAULT_LATCH_EN to make fault_bits/timeout_err sticky until a fault_clr pulse.
module thermocouple_scanner #(
    parameter int N_CH           = 4,
    parameter int CLK_FREQ       = 10,
    parameter int STARTUP_UNITS  = 3,
    parameter int HOLD_UNITS     = 1,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CBITS          = 8,
    localparam int CHW           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_not_busy,
    input  logic [31:0]          spi_rx_data,
    input  logic                 fault_clr,
    output logic                 spi_ena,
    output logic [CHW-1:0]       spi_ch_sel,
    output logic [14*N_CH-1:0]   tc_temp_data,
    output logic [12*N_CH-1:0]   junction_temp_data,
    output logic [4*N_CH-1:0]    fault_bits,
    output logic [N_CH-1:0]      ch_valid,
    output logic [N_CH-1:0]      timeout_err,
    output logic                 any_fault
);
    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam logic [CBITS-1:0] STARTUP_MAX = CBITS'(CLK_FREQ * STARTUP_UNITS);
    localparam logic [CBITS-1:0] HOLD_MAX    = CBITS'(CLK_FREQ * HOLD_UNITS);
    localparam logic [CBITS-1:0] TO_MAX      = CBITS'(TIMEOUT_CYCLES - 1);
    localparam logic [CHW-1:0]   CH_LAST     = CHW'(N_CH - 1);

    state_t               state_q, state_d;
    logic [CBITS-1:0]     cnt_q, cnt_d;
    logic [CHW-1:0]       ch_q, ch_d;
    logic                 spi_ena_q, spi_ena_d;
    logic [14*N_CH-1:0]   tc_q, tc_d;
    logic [12*N_CH-1:0]   jn_q, jn_d;
    logic [4*N_CH-1:0]    fault_q, fault_d;
    logic [N_CH-1:0]      valid_q, valid_d;
    logic [N_CH-1:0]      tmo_q, tmo_d;
    logic [3:0]           frame_fault;
    logic                 unused_bits;

    assign frame_fault = {spi_rx_data[16], spi_rx_data[2:0]};
`ifdef FAULT_LATCH_EN
    assign unused_bits = ^{spi_rx_data[17], spi_rx_data[3]};
`else
    assign unused_bits = ^{spi_rx_data[17], spi_rx_data[3], fault_clr};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        tc_d    = tc_q;
        jn_d    = jn_q;
        fault_d = fault_q;
        valid_d = valid_q;
        tmo_d   = tmo_q;
`ifdef FAULT_LATCH_EN
        if (fault_clr) begin
            fault_d = '0;
            tmo_d   = '0;
        end
`endif
        case (state_q)
            ST_STARTUP: begin
                state_d = (cnt_q == STARTUP_MAX) ? ST_REQ : ST_STARTUP;
                cnt_d   = (cnt_q == STARTUP_MAX) ? '0 : cnt_q + 1'b1;
                ch_d    = '0;
            end
            ST_REQ: begin
                if (!spi_not_busy) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == TO_MAX) begin
                    state_d     = ST_HOLD;
                    cnt_d       = '0;
                    tmo_d[ch_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: state_d = spi_not_busy ? ST_CAPTURE : ST_WAIT;
            ST_CAPTURE: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (CHW'(k) == ch_q) begin
                        tc_d[14*k +: 14] = spi_rx_data[31:18];
                        jn_d[12*k +: 12] = spi_rx_data[15:4];
                        valid_d[k]       = ~spi_rx_data[16];
`ifdef FAULT_LATCH_EN
                        fault_d[4*k +: 4] = fault_d[4*k +: 4] | frame_fault;
`else
                        fault_d[4*k +: 4] = frame_fault;
                        tmo_d[k]          = 1'b0;
`endif
                    end
                end
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_MAX) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                    ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_REQ;
                cnt_d   = '0;
                ch_d    = '0;
            end
        endcase
        // The request line is registered: it is high exactly while the FSM sits in REQ
        spi_ena_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STARTUP;
            cnt_q     <= '0;
            ch_q      <= '0;
            spi_ena_q <= 1'b0;
            tc_q      <= '0;
            jn_q      <= '0;
            fault_q   <= '0;
            valid_q   <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            spi_ena_q <= spi_ena_d;
            tc_q      <= tc_d;
            jn_q      <= jn_d;
            fault_q   <= fault_d;
            valid_q   <= valid_d;
            tmo_q     <= tmo_d;
        end
    end

    assign spi_ena            = spi_ena_q;
    assign spi_ch_sel         = ch_q;
    assign tc_temp_data       = tc_q;
    assign junction_temp_data = jn_q;
    assign fault_bits         = fault_q;
    assign ch_valid           = valid_q;
    assign timeout_err        = tmo_q;
    assign any_fault          = (|fault_q) | (|tmo_q);
endmodule

// File: tb/tb_thermocouple_scanner.sv
// tb_thermocouple_scanner: directed-vector bench for thermocouple_scanner (N_CH=4, CLK_FREQ=10).
module tb_thermocouple_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        spi_not_busy = 1'b1;
    logic [31:0] spi_rx_data = '0;
    logic        fault_clr = 1'b0;
    logic        spi_ena;
    logic [1:0]  spi_ch_sel;
    logic [55:0] tc_temp_data;
    logic [47:0] junction_temp_data;
    logic [15:0] fault_bits;
    logic [3:0]  ch_valid;
    logic [3:0]  timeout_err;
    logic        any_fault;

    int n_cmp = 0;
    int n_err = 0;

    logic [55:0] e_tc;
    logic [47:0] e_j;
    logic [15:0] e_f;
    logic [3:0]  e_v;
    logic [3:0]  e_to;

    logic [13:0] b_tc [4] = '{14'h3FFF, 14'h0001, 14'h2222, 14'h1555};
    logic [11:0] b_j  [4] = '{12'hABC, 12'hFFF, 12'h333, 12'h0AA};
    int          b_ch [4] = '{3, 0, 1, 2};

    thermocouple_scanner dut (
        .clk(clk), .rst_n(rst_n), .spi_not_busy(spi_not_busy), .spi_rx_data(spi_rx_data),
        .fault_clr(fault_clr), .spi_ena(spi_ena), .spi_ch_sel(spi_ch_sel),
        .tc_temp_data(tc_temp_data), .junction_temp_data(junction_temp_data),
        .fault_bits(fault_bits), .ch_valid(ch_valid), .timeout_err(timeout_err),
        .any_fault(any_fault)
    );

    always #5 clk = ~clk;

    // Frame layout with reserved bits 17 and 3 set so they must be ignored
    function automatic logic [31:0] mk(input logic [13:0] t, input logic [11:0] j, input logic [3:0] f);
        return {t, 1'b1, f[3], j, 1'b1, f[2:0]};
    endfunction

    task automatic serve(input logic [31:0] f, output int lat);
        lat = 0;
        while (!spi_ena && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!spi_ena) begin
            n_cmp++; n_err++;
            $display("FAIL serve_wait: spi_ena=%b after %0d cycles, want 1", spi_ena, lat);
        end
        spi_not_busy = 1'b0;
        repeat (4) @(negedge clk);
        spi_rx_data  = f;
        spi_not_busy = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        int n;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({spi_ena, spi_ch_sel, tc_temp_data, junction_temp_data, fault_bits, ch_valid, timeout_err, any_fault} !== '0) begin
            n_err++; $display("FAIL reset_outputs: some output nonzero during reset, want all 0");
        end
        rst_n = 1'b1;
        n = 0;
        while (!spi_ena && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n !== 31) begin n_err++; $display("FAIL startup_delay: got %0d want 31", n); end
        n_cmp++;
        if (spi_ch_sel !== 2'd0) begin n_err++; $display("FAIL startup_sel: got %0d want 0", spi_ch_sel); end
    endtask

    task automatic test_capture;
        int lat;
        serve(32'h1234_5670, lat);
        e_tc = {42'h0, 14'h048D};
        e_j  = {36'h0, 12'h567};
        e_f  = '0;
        e_v  = 4'b0001;
        e_to = '0;
        n_cmp++;
        if (tc_temp_data !== e_tc) begin n_err++; $display("FAIL cap_tc: got %h want %h", tc_temp_data, e_tc); end
        n_cmp++;
        if (junction_temp_data !== e_j) begin n_err++; $display("FAIL cap_j: got %h want %h", junction_temp_data, e_j); end
        n_cmp++;
        if (fault_bits !== e_f) begin n_err++; $display("FAIL cap_f: got %h want %h", fault_bits, e_f); end
        n_cmp++;
        if (ch_valid !== e_v) begin n_err++; $display("FAIL cap_v: got %b want %b", ch_valid, e_v); end
        n_cmp++;
        if (any_fault !== 1'b0) begin n_err++; $display("FAIL cap_any: got %b want 0", any_fault); end
    endtask

    task automatic test_fault;
        int lat;
        serve(32'h0003_000D, lat);
        e_f = 16'h00D0;
        n_cmp++;
        if (lat !== 11) begin n_err++; $display("FAIL fault_hold: got %0d want 11", lat); end
        n_cmp++;
        if (spi_ch_sel !== 2'd1) begin n_err++; $display("FAIL fault_sel: got %0d want 1", spi_ch_sel); end
        n_cmp++;
        if (fault_bits !== e_f) begin n_err++; $display("FAIL fault_bits: got %h want %h", fault_bits, e_f); end
        n_cmp++;
        if (ch_valid !== e_v) begin n_err++; $display("FAIL fault_v: got %b want %b", ch_valid, e_v); end
        n_cmp++;
        if (any_fault !== 1'b1) begin n_err++; $display("FAIL fault_any: got %b want 1", any_fault); end
        n_cmp++;
        if (tc_temp_data !== e_tc) begin n_err++; $display("FAIL fault_tc: got %h want %h", tc_temp_data, e_tc); end
`ifndef FAULT_LATCH_EN
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fault_bits !== e_f) begin n_err++; $display("FAIL clr_ignored: got %h want %h", fault_bits, e_f); end
`endif
    endtask

    task automatic test_timeout;
        int n;
        n = 0;
        while (!spi_ena && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (spi_ch_sel !== 2'd2 || !spi_ena) begin n_err++; $display("FAIL to_sel: got %0d/%b want 2/1", spi_ch_sel, spi_ena); end
        repeat (60) @(negedge clk);
        n_cmp++;
        if (timeout_err !== 4'b0000) begin n_err++; $display("FAIL to_early: got %b want 0000", timeout_err); end
        repeat (10) @(negedge clk);
        e_to = 4'b0100;
        n_cmp++;
        if (timeout_err !== e_to) begin n_err++; $display("FAIL to_set: got %b want %b", timeout_err, e_to); end
        n_cmp++;
        if (any_fault !== 1'b1) begin n_err++; $display("FAIL to_any: got %b want 1", any_fault); end
        n_cmp++;
        if (spi_ena !== 1'b0) begin n_err++; $display("FAIL to_ena: got %b want 0", spi_ena); end
        n_cmp++;
        if (ch_valid !== e_v) begin n_err++; $display("FAIL to_v: got %b want %b", ch_valid, e_v); end
    endtask

    task automatic test_back_to_back;
        int lat;
        for (int i = 0; i < 4; i++) begin
            serve(mk(b_tc[i], b_j[i], 4'h0), lat);
            e_tc[14*b_ch[i] +: 14] = b_tc[i];
            e_j[12*b_ch[i] +: 12]  = b_j[i];
            e_v[b_ch[i]]           = 1'b1;
`ifndef FAULT_LATCH_EN
            e_f[4*b_ch[i] +: 4]    = 4'h0;
            e_to[b_ch[i]]          = 1'b0;
`endif
            if (i > 0) begin
                n_cmp++;
                if (lat !== 11) begin n_err++; $display("FAIL b2b_hold%0d: got %0d want 11", i, lat); end
            end
            n_cmp++;
            if (spi_ch_sel !== 2'(b_ch[i])) begin n_err++; $display("FAIL b2b_sel%0d: got %0d want %0d", i, spi_ch_sel, b_ch[i]); end
            n_cmp++;
            if (tc_temp_data !== e_tc) begin n_err++; $display("FAIL b2b_tc%0d: got %h want %h", i, tc_temp_data, e_tc); end
            n_cmp++;
            if (junction_temp_data !== e_j) begin n_err++; $display("FAIL b2b_j%0d: got %h want %h", i, junction_temp_data, e_j); end
            n_cmp++;
            if (fault_bits !== e_f) begin n_err++; $display("FAIL b2b_f%0d: got %h want %h", i, fault_bits, e_f); end
            n_cmp++;
            if (ch_valid !== e_v) begin n_err++; $display("FAIL b2b_v%0d: got %b want %b", i, ch_valid, e_v); end
            n_cmp++;
            if (timeout_err !== e_to) begin n_err++; $display("FAIL b2b_to%0d: got %b want %b", i, timeout_err, e_to); end
        end
        n_cmp++;
        if (any_fault !== ((|e_f) | (|e_to))) begin n_err++; $display("FAIL b2b_any: got %b want %b", any_fault, (|e_f) | (|e_to)); end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fault_bits !== 16'h0) begin n_err++; $display("FAIL clr_f: got %h want 0000", fault_bits); end
        n_cmp++;
        if (timeout_err !== 4'b0) begin n_err++; $display("FAIL clr_to: got %b want 0000", timeout_err); end
        n_cmp++;
        if (ch_valid !== 4'b1111) begin n_err++; $display("FAIL clr_v: got %b want 1111", ch_valid); end
        n_cmp++;
        if (any_fault !== 1'b0) begin n_err++; $display("FAIL clr_any: got %b want 0", any_fault); end
    endtask

    task automatic test_reset_mid_wait;
        int n;
        n = 0;
        while (!spi_ena && n < 200) begin
            @(negedge clk);
            n++;
        end
        spi_not_busy = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({spi_ena, spi_ch_sel, tc_temp_data, junction_temp_data, fault_bits, ch_valid, timeout_err, any_fault} !== '0) begin
            n_err++; $display("FAIL async_reset: outputs nonzero before next edge, want all 0");
        end
        @(negedge clk);
        spi_not_busy = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!spi_ena && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n !== 31) begin n_err++; $display("FAIL restart_delay: got %0d want 31", n); end
        n_cmp++;
        if (spi_ch_sel !== 2'd0) begin n_err++; $display("FAIL restart_sel: got %0d want 0", spi_ch_sel); end
        n_cmp++;
        if (tc_temp_data !== '0 || ch_valid !== '0) begin n_err++; $display("FAIL restart_data: got %h/%b want 0/0", tc_temp_data, ch_valid); end
    endtask

    initial begin
        test_reset;
        test_capture;
        test_fault;
        test_timeout;
        test_back_to_back;
        test_reset_mid_wait;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
